// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Program sequencer that sits in front of the instruction decoder. It holds a
// small loadable instruction store and a program counter. It fetches one
// 18-bit word at a time and presents it to the decoder over an
// id / id_valid / ready handshake. It follows unconditional jumps and stops
// when it issues the halt opcode.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (store contents are kept)
//   load_en    write load_data into the store at load_addr (IDLE/HALTED only)
//   load_addr  store write address
//   load_data  instruction word to store
//   start      single-cycle pulse; begin execution at address 0
//   ready      decoder accepts the presented word this cycle
//   id         instruction word presented to the decoder
//   id_valid   id holds a valid instruction
//   pc         address of the word in id, or of the word being fetched
//   busy       high while fetching or issuing
//   halted     high after a halt instruction has been accepted
//   load_err   one-cycle pulse after a load attempted while busy
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int           DEPTH   = 16,
    parameter int           AW      = 4,
    parameter logic [4:0]   HALT_OP = 5'b10001,
    parameter logic [4:0]   JMP_OP  = 5'b10101
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [17:0]     load_data,
    input  logic            start,
    input  logic            ready,
    output logic [17:0]     id,
    output logic            id_valid,
    output logic [AW-1:0]   pc,
    output logic            busy,
    output logic            halted,
    output logic            load_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALTED
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [17:0]    mem [DEPTH];
    logic [17:0]    id_next;
    logic           id_valid_next;
    logic [AW-1:0]  pc_next;
    logic           load_err_next;
    logic           can_load;
    logic           accept;

    // Loads are only safe while no program is running.
    assign can_load = (state == IDLE) || (state == HALTED);
    assign accept   = id_valid && ready;
    assign busy     = (state == FETCH) || (state == ISSUE);
    assign halted   = (state == HALTED);

    // Instruction store. It is deliberately not reset so a program survives a
    // reset. A write that lands in the same cycle as start is committed at
    // that edge, so the following FETCH already reads the new word.
    always_ff @(posedge clk) begin
        if (load_en && can_load) begin
            mem[load_addr] <= load_data;
        end
    end

    // Next-state and datapath decisions for the fetch/issue loop.
    always_comb begin
        state_next    = state;
        id_next       = id;
        id_valid_next = id_valid;
        pc_next       = pc;
        load_err_next = load_en && !can_load;

        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                id_next       = mem[pc];
                id_valid_next = 1'b1;
                state_next    = ISSUE;
            end
            ISSUE: begin
                // id keeps its last value after acceptance; only id_valid
                // drops. pc wraps naturally because DEPTH is 2**AW.
                if (accept) begin
                    id_valid_next = 1'b0;
                    if (id[17:13] == HALT_OP) begin
                        state_next = HALTED;
                    end else if (id[17:13] == JMP_OP) begin
                        pc_next    = id[AW-1:0];
                        state_next = FETCH;
                    end else begin
                        pc_next    = pc + AW'(1);
                        state_next = FETCH;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers. Reset takes priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            id       <= '0;
            id_valid <= 1'b0;
            pc       <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= state_next;
            id       <= id_next;
            id_valid <= id_valid_next;
            pc       <= pc_next;
            load_err <= load_err_next;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Self-checking bench for instr_sequencer. A behavioural model walks the
// program stored in model_mem (halt stops, jump redirects, otherwise next
// address modulo 16) and produces the expected stream of issued words and
// addresses. That stream is compared with what the DUT hands over the
// handshake.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam logic [4:0]  HALT_OP = 5'b10001;
    localparam logic [4:0]  JMP_OP  = 5'b10101;
    localparam logic [17:0] HALT_W  = {5'b10001, 13'd0};
    localparam logic [17:0] W0 = 18'b110010100011001001;
    localparam logic [17:0] W1 = 18'b011110110100001100;
    localparam logic [17:0] W2 = 18'b100110110101100100;
    localparam logic [17:0] W3 = 18'b100010111011001100;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [17:0] load_data;
    logic        start;
    logic        ready;
    logic [17:0] id;
    logic        id_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        halted;
    logic        load_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [17:0] model_mem [16];
    logic [17:0] obs_id [$];
    logic [3:0]  obs_pc [$];
    int          obs_cyc [$];
    logic [17:0] exp_id [$];
    logic [3:0]  exp_pc [$];
    bit          exp_halt;
    logic [3:0]  exp_final_pc;

    instr_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .ready     (ready),
        .id        (id),
        .id_valid  (id_valid),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        load_en = 1'b0;
        start   = 1'b0;
        ready   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [17:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
        model_mem[a] = d;
    endtask

    function automatic logic [17:0] rand_plain();
        logic [17:0] w;
        do begin
            w = 18'($urandom);
        end while (w[17:13] == HALT_OP || w[17:13] == JMP_OP);
        return w;
    endfunction

    // Reference model: walk the program at the instruction level.
    task automatic model_run(input int max_issues);
        int          mpc;
        logic [17:0] w;
        exp_id.delete();
        exp_pc.delete();
        exp_halt     = 1'b0;
        exp_final_pc = '0;
        mpc = 0;
        for (int k = 0; k < max_issues; k++) begin
            w = model_mem[mpc];
            exp_id.push_back(w);
            exp_pc.push_back(4'(mpc));
            if (w[17:13] == HALT_OP) begin
                exp_halt     = 1'b1;
                exp_final_pc = 4'(mpc);
                break;
            end else if (w[17:13] == JMP_OP) begin
                mpc = int'(w[3:0]);
            end else begin
                mpc = (mpc + 1) % 16;
            end
        end
    endtask

    // Drive a run and record every accepted word; no checking here.
    task automatic run_program(input bit do_start, input int max_issues,
                               input int stall_pct, output bit timed_out);
        int cycles;
        obs_id.delete();
        obs_pc.delete();
        obs_cyc.delete();
        if (do_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        cycles = 0;
        while (obs_id.size() < max_issues && !halted && cycles < 2000) begin
            ready = ($urandom_range(99) >= stall_pct);
            if (id_valid && ready) begin
                obs_id.push_back(id);
                obs_pc.push_back(pc);
                obs_cyc.push_back(cycles);
            end
            tick();
            cycles++;
        end
        ready     = 1'b0;
        timed_out = (cycles >= 2000);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_en = 1'b0; start = 1'b1; ready = 1'b0;
        load_addr = '0; load_data = '0;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        tests_run++; if (id !== 18'd0) begin tests_failed++; $display("[TB] FAIL reset_id: got %h want 0", id); end
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_id_valid: got %b want 0", id_valid); end
        tests_run++; if (pc !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_pc: got %0d want 0", pc); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
        tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_load_err: got %b want 0", load_err); end
    endtask

    task automatic test_basic_program();
        logic [17:0] w [4];
        bit to;
        w[0] = W0; w[1] = W1; w[2] = W2; w[3] = W3;
        do_reset();
        for (int a = 0; a < 4; a++) load_word(4'(a), w[a]);
        run_program(1'b1, 10, 0, to);
        tests_run++; if (to) begin tests_failed++; $display("[TB] FAIL basic_timeout: got timeout want halt"); end
        tests_run++; if (obs_id.size() != 4) begin tests_failed++; $display("[TB] FAIL basic_count: got %0d want 4", obs_id.size()); end
        for (int i = 0; i < 4 && i < obs_id.size(); i++) begin
            tests_run++; if (obs_id[i] !== w[i]) begin tests_failed++; $display("[TB] FAIL basic_id[%0d]: got %h want %h", i, obs_id[i], w[i]); end
            tests_run++; if (obs_pc[i] !== 4'(i)) begin tests_failed++; $display("[TB] FAIL basic_pc[%0d]: got %0d want %0d", i, obs_pc[i], i); end
            if (i > 0) begin
                tests_run++; if (obs_cyc[i] - obs_cyc[i-1] != 2) begin tests_failed++; $display("[TB] FAIL basic_spacing[%0d]: got %0d want 2", i, obs_cyc[i] - obs_cyc[i-1]); end
            end
        end
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_halted: got %b want 1", halted); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy: got %b want 0", busy); end
        tests_run++; if (id_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_id_valid: got %b want 0", id_valid); end
        tests_run++; if (pc !== 4'd3) begin tests_failed++; $display("[TB] FAIL basic_final_pc: got %0d want 3", pc); end
    endtask

    task automatic test_stall();
        bit to;
        bit found;
        do_reset();
        start = 1'b1; ready = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (id_valid && pc == 4'd1) begin found = 1'b1; break; end
            tick();
        end
        tests_run++; if (!found) begin tests_failed++; $display("[TB] FAIL stall_reach_addr1: got not presented want presented"); end
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tests_run++; if (id !== W1) begin tests_failed++; $display("[TB] FAIL stall_id[%0d]: got %h want %h", k, id, W1); end
            tests_run++; if (pc !== 4'd1) begin tests_failed++; $display("[TB] FAIL stall_pc[%0d]: got %0d want 1", k, pc); end
            tests_run++; if (id_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_valid[%0d]: got %b want 1", k, id_valid); end
            tick();
        end
        run_program(1'b0, 10, 0, to);
        tests_run++; if (obs_id.size() != 3 || to) begin tests_failed++; $display("[TB] FAIL stall_resume_count: got %0d want 3", obs_id.size()); end
        if (obs_id.size() == 3) begin
            tests_run++; if (obs_id[0] !== W1 || obs_id[1] !== W2 || obs_id[2] !== W3) begin tests_failed++; $display("[TB] FAIL stall_resume_ids: got %h %h %h want %h %h %h", obs_id[0], obs_id[1], obs_id[2], W1, W2, W3); end
            tests_run++; if (obs_pc[0] !== 4'd1 || obs_pc[2] !== 4'd3) begin tests_failed++; $display("[TB] FAIL stall_resume_pcs: got %0d..%0d want 1..3", obs_pc[0], obs_pc[2]); end
        end
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_halted: got %b want 1", halted); end
    endtask

    task automatic test_jump();
        bit to;
        logic [17:0] jw;
        jw = 18'b101010000000000010;
        do_reset();
        load_word(4'd0, jw);
        load_word(4'd1, HALT_W);
        load_word(4'd2, HALT_W);
        run_program(1'b1, 10, 25, to);
        tests_run++; if (obs_id.size() != 2 || to) begin tests_failed++; $display("[TB] FAIL jump_count: got %0d want 2", obs_id.size()); end
        if (obs_id.size() == 2) begin
            tests_run++; if (obs_id[0] !== jw || obs_pc[0] !== 4'd0) begin tests_failed++; $display("[TB] FAIL jump_first: got %h@%0d want %h@0", obs_id[0], obs_pc[0], jw); end
            tests_run++; if (obs_id[1] !== HALT_W || obs_pc[1] !== 4'd2) begin tests_failed++; $display("[TB] FAIL jump_target: got %h@%0d want %h@2", obs_id[1], obs_pc[1], HALT_W); end
        end
        tests_run++; if (halted !== 1'b1 || pc !== 4'd2) begin tests_failed++; $display("[TB] FAIL jump_halt: got halted=%b pc=%0d want halted=1 pc=2", halted, pc); end
    endtask

    task automatic test_wrap();
        bit to;
        do_reset();
        for (int a = 0; a < 16; a++) load_word(4'(a), rand_plain());
        run_program(1'b1, 17, 30, to);
        tests_run++; if (obs_id.size() != 17 || to) begin tests_failed++; $display("[TB] FAIL wrap_count: got %0d want 17", obs_id.size()); end
        for (int i = 0; i < obs_id.size(); i++) begin
            tests_run++; if (obs_pc[i] !== 4'(i % 16) || obs_id[i] !== model_mem[i % 16]) begin tests_failed++; $display("[TB] FAIL wrap_issue[%0d]: got %h@%0d want %h@%0d", i, obs_id[i], obs_pc[i], model_mem[i % 16], i % 16); end
        end
        tests_run++; if (halted !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_not_halted: got %b want 0", halted); end
        // With address 0 rewritten as a halt, the next run stops on it.
        do_reset();
        load_word(4'd0, HALT_W);
        run_program(1'b1, 17, 30, to);
        tests_run++; if (obs_id.size() != 1 || halted !== 1'b1 || pc !== 4'd0) begin tests_failed++; $display("[TB] FAIL wrap_halt_addr0: got n=%0d halted=%b pc=%0d want n=1 halted=1 pc=0", obs_id.size(), halted, pc); end
    endtask

    task automatic test_load_err_and_reset();
        bit to;
        bit found;
        do_reset();
        load_word(4'd0, W0); load_word(4'd1, W1); load_word(4'd2, W2); load_word(4'd3, W3);
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (id_valid) begin found = 1'b1; break; end
            tick();
        end
        tests_run++; if (!found) begin tests_failed++; $display("[TB] FAIL lerr_reach_issue: got no id_valid want id_valid"); end
        load_en = 1'b1; load_addr = 4'd2; load_data = ~W2;
        tick();
        load_en = 1'b0;
        tests_run++; if (load_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL lerr_pulse: got %b want 1", load_err); end
        tick();
        tests_run++; if (load_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL lerr_one_cycle: got %b want 0", load_err); end
        tests_run++; if (id_valid !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL lerr_still_issue: got valid=%b busy=%b want 1 1", id_valid, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if (id_valid !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || halted !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst: got valid=%b pc=%0d busy=%b halted=%b want 0 0 0 0", id_valid, pc, busy, halted); end
        model_run(10);
        run_program(1'b1, 10, 20, to);
        tests_run++; if (obs_id.size() != exp_id.size() || to) begin tests_failed++; $display("[TB] FAIL lerr_rerun_count: got %0d want %0d", obs_id.size(), exp_id.size()); end
        for (int i = 0; i < obs_id.size() && i < exp_id.size(); i++) begin
            tests_run++; if (obs_id[i] !== exp_id[i]) begin tests_failed++; $display("[TB] FAIL lerr_store[%0d]: got %h want %h", i, obs_id[i], exp_id[i]); end
        end
    endtask

    task automatic test_load_with_start();
        bit to;
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("[TB] FAIL lws_precond_halted: got %b want 1", halted); end
        load_en = 1'b1; load_addr = 4'd0; load_data = HALT_W; start = 1'b1;
        tick();
        load_en = 1'b0; start = 1'b0;
        model_mem[0] = HALT_W;
        run_program(1'b0, 10, 0, to);
        tests_run++; if (obs_id.size() != 1 || to) begin tests_failed++; $display("[TB] FAIL lws_count: got %0d want 1", obs_id.size()); end
        if (obs_id.size() >= 1) begin
            tests_run++; if (obs_id[0] !== HALT_W || obs_pc[0] !== 4'd0) begin tests_failed++; $display("[TB] FAIL lws_first_word: got %h@%0d want %h@0", obs_id[0], obs_pc[0], HALT_W); end
        end
        tests_run++; if (halted !== 1'b1) begin tests_failed++; $display("[TB] FAIL lws_halted: got %b want 1", halted); end
    endtask

    task automatic test_random_programs();
        bit to;
        int r;
        logic [17:0] w;
        for (int it = 0; it < 25; it++) begin
            do_reset();
            for (int a = 0; a < 16; a++) begin
                r = $urandom_range(9);
                w = 18'($urandom);
                if (r == 0)      w[17:13] = HALT_OP;
                else if (r <= 2) w[17:13] = JMP_OP;
                else             w = rand_plain();
                load_word(4'(a), w);
            end
            model_run(24);
            run_program(1'b1, 24, $urandom_range(60), to);
            tests_run++; if (obs_id.size() != exp_id.size() || to) begin tests_failed++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", it, obs_id.size(), exp_id.size()); end
            for (int i = 0; i < obs_id.size() && i < exp_id.size(); i++) begin
                tests_run++; if (obs_id[i] !== exp_id[i] || obs_pc[i] !== exp_pc[i]) begin tests_failed++; $display("[TB] FAIL rand%0d_issue[%0d]: got %h@%0d want %h@%0d", it, i, obs_id[i], obs_pc[i], exp_id[i], exp_pc[i]); end
            end
            tests_run++; if (halted !== exp_halt) begin tests_failed++; $display("[TB] FAIL rand%0d_halted: got %b want %b", it, halted, exp_halt); end
            if (exp_halt) begin
                tests_run++; if (pc !== exp_final_pc) begin tests_failed++; $display("[TB] FAIL rand%0d_final_pc: got %0d want %0d", it, pc, exp_final_pc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_program();
        test_stall();
        test_jump();
        test_wrap();
        test_load_err_and_reset();
        test_load_with_start();
        test_random_programs();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
